// File: rtl/rf_1wnr_sync_wrapper.sv
// Register file: one masked write port, NUM_RD read ports with 0/1/2-cycle latency, zero-init engine.
// Define RF_PARITY_EN to add per-lane even parity storage with the par_inj / rd_perr ports.
module rf_1wnr_sync_wrapper #(
  parameter int READ_DELAY = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_GRAN  = 8,
  parameter int RF_DEPTH   = 2**ADDR_WIDTH,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init_start,
  output logic                           init_busy,
  output logic                           init_done,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/MASK_GRAN-1:0] wmask,
  output logic                           wr_drop,
  input  logic [NUM_RD-1:0]              re,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
`ifdef RF_PARITY_EN
  input  logic                           par_inj,
  output logic [NUM_RD-1:0]              rd_perr,
`endif
  output logic [NUM_RD-1:0]              rvalid
);

  localparam int LANES = DATA_WIDTH / MASK_GRAN;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(RF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(RF_DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_INIT} state_e;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [LANES-1:0]      lane_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (init_start) begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      ST_INIT: begin
        if (init_start) begin
          cnt_d = '0;                      // restart; the aborted pass never signals done
        end else if (cnt_q == LAST_A) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    init_busy = (state_q == ST_INIT);
    init_done = done_q;
    wr_drop   = drop_q;
  end

  // Single array write port shared by the init engine and user writes.
  logic                  init_wr, usr_wr, mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  word_t                 mem_wd;
  lane_t                 lane_en;

  always_comb begin
    init_wr = (state_q == ST_INIT);
    usr_wr  = we && !init_wr && in_range(waddr);
    drop_d  = we && !usr_wr;
    mem_we  = init_wr || usr_wr;
    mem_wa  = init_wr ? cnt_q : waddr;
    mem_wd  = init_wr ? '0 : wdata;
    lane_en = init_wr ? '1 : wmask;
  end

  word_t mem_q [RF_DEPTH];

  // NOTE: the array is reset so contents are defined without running init; it maps to flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int l = 0; l < LANES; l++)
        if (lane_en[l]) mem_q[mem_wa][l*MASK_GRAN +: MASK_GRAN] <= mem_wd[l*MASK_GRAN +: MASK_GRAN];
    end
  end

  logic [ADDR_WIDTH-1:0]           ra [NUM_RD];
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] sel_word;

  // Write-first bypass only exists on registered read paths.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra[k] = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (in_range(ra[k])) sel_word[k] = mem_q[ra[k]];
      if (READ_DELAY != 0 && mem_we && mem_wa == ra[k])
        for (int l = 0; l < LANES; l++)
          if (lane_en[l]) sel_word[k][l*MASK_GRAN +: MASK_GRAN] = mem_wd[l*MASK_GRAN +: MASK_GRAN];
    end
  end

`ifdef RF_PARITY_EN
  lane_t                        mem_wp;
  lane_t                        par_q [RF_DEPTH];
  logic [NUM_RD-1:0][LANES-1:0] sel_par;
  logic [NUM_RD-1:0]            perr_now;

  always_comb begin
    mem_wp = '0;
    for (int l = 0; l < LANES; l++)
      mem_wp[l] = init_wr ? 1'b0 : (^wdata[l*MASK_GRAN +: MASK_GRAN]) ^ par_inj;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) par_q[i] <= '0;
    end else if (mem_we) begin
      for (int l = 0; l < LANES; l++)
        if (lane_en[l]) par_q[mem_wa][l] <= mem_wp[l];
    end
  end

  always_comb begin
    sel_par  = '0;
    perr_now = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (in_range(ra[k])) sel_par[k] = par_q[ra[k]];
      if (READ_DELAY != 0 && mem_we && mem_wa == ra[k])
        for (int l = 0; l < LANES; l++)
          if (lane_en[l]) sel_par[k][l] = mem_wp[l];
      for (int l = 0; l < LANES; l++)
        perr_now[k] = perr_now[k] | (^{sel_word[k][l*MASK_GRAN +: MASK_GRAN], sel_par[k][l]});
    end
  end
`endif

  generate
    if (READ_DELAY == 0) begin : g_rd0
      assign rdata  = sel_word;
      assign rvalid = re;
`ifdef RF_PARITY_EN
      assign rd_perr = re & perr_now;
`endif
    end else begin : g_rd12
      logic [NUM_RD-1:0][DATA_WIDTH-1:0] s1_q;
      logic [NUM_RD-1:0]                 v1_q;
      logic [NUM_RD-1:0]                 p1_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q <= '0;
          v1_q <= '0;
          p1_q <= '0;
        end else begin
          v1_q <= re;
`ifdef RF_PARITY_EN
          p1_q <= re & perr_now;
`endif
          for (int k = 0; k < NUM_RD; k++)
            if (re[k]) s1_q[k] <= sel_word[k];
        end
      end

      if (READ_DELAY == 1) begin : g_rd1
        assign rdata  = s1_q;
        assign rvalid = v1_q;
`ifdef RF_PARITY_EN
        assign rd_perr = p1_q;
`endif
      end else begin : g_rd2
        logic [NUM_RD-1:0][DATA_WIDTH-1:0] s2_q;
        logic [NUM_RD-1:0]                 v2_q;
        logic [NUM_RD-1:0]                 p2_q;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            s2_q <= '0;
            v2_q <= '0;
            p2_q <= '0;
          end else begin
            s2_q <= s1_q;
            v2_q <= v1_q;
            p2_q <= p1_q;
          end
        end

        assign rdata  = s2_q;
        assign rvalid = v2_q;
`ifdef RF_PARITY_EN
        assign rd_perr = p2_q;
`endif
      end
    end
  endgenerate

endmodule
